// File: rtl/conv_add_tree_pkg.sv
// Shared constants for the convolution adder tree: default widths,
// pipeline depth and a helper for the pairwise reduction sizes.
package conv_add_tree_pkg;

  // Width of each signed product arriving from the multiply/add buffer.
  localparam int CONV_OUT_BIT_WIDTH = 16;

  // Accumulator width: +5 bits for the 25-way sum, +4 for up to 16 channels.
  localparam int ACC_BIT_WIDTH = CONV_OUT_BIT_WIDTH + 9;

  // Registers from product input to conv_result_valid: 5 tree, 1 acc, 1 out.
  localparam int ADD_TREE_LATENCY = 7;

  // Products per 5x5 window.
  localparam int N_PRODUCTS = 25;

  // Number of outputs of one pairwise-sum stage (odd leftover passes through).
  function automatic int pair_count(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/conv_add_tree_add_pair_stage.sv
// One registered level of the adder tree: adjacent inputs are summed in
// pairs; an odd leftover input is registered unchanged in the last slot.
module add_pair_stage
  import conv_add_tree_pkg::*;
#(
  parameter int N_IN  = 25,
  parameter int W     = ACC_BIT_WIDTH,
  localparam int N_OUT = pair_count(N_IN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in_data  [N_IN],
  output logic signed [W-1:0] out_data [N_OUT]
);

  // Pairwise sums load every cycle; bubbles simply carry don't-care data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) begin
        out_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN / 2; i++) begin
        out_data[i] <= in_data[2*i] + in_data[2*i+1];
      end
      if (N_IN % 2 == 1) begin
        out_data[N_OUT-1] <= in_data[N_IN-1];
      end
    end
  end

endmodule

// File: rtl/conv_add_tree.sv
// Pipelined 25-input adder tree with cross-channel accumulation, bias add,
// arithmetic rescale, optional ReLU and saturation to the output word.
//
// Handshake: in_valid qualifies the products and ch_first_i/ch_last_i for one
// beat; there is no ready, every valid beat is consumed. conv_result_valid is
// a one-cycle strobe per completed pixel and downstream must accept every one.
module conv_add_tree
  import conv_add_tree_pkg::*;
#(
  parameter int IN_W       = CONV_OUT_BIT_WIDTH,
  parameter int ACC_W      = IN_W + 9,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  mul_result_0_i,
  input  logic signed [IN_W-1:0]  mul_result_1_i,
  input  logic signed [IN_W-1:0]  mul_result_2_i,
  input  logic signed [IN_W-1:0]  mul_result_3_i,
  input  logic signed [IN_W-1:0]  mul_result_4_i,
  input  logic signed [IN_W-1:0]  mul_result_5_i,
  input  logic signed [IN_W-1:0]  mul_result_6_i,
  input  logic signed [IN_W-1:0]  mul_result_7_i,
  input  logic signed [IN_W-1:0]  mul_result_8_i,
  input  logic signed [IN_W-1:0]  mul_result_9_i,
  input  logic signed [IN_W-1:0]  mul_result_10_i,
  input  logic signed [IN_W-1:0]  mul_result_11_i,
  input  logic signed [IN_W-1:0]  mul_result_12_i,
  input  logic signed [IN_W-1:0]  mul_result_13_i,
  input  logic signed [IN_W-1:0]  mul_result_14_i,
  input  logic signed [IN_W-1:0]  mul_result_15_i,
  input  logic signed [IN_W-1:0]  mul_result_16_i,
  input  logic signed [IN_W-1:0]  mul_result_17_i,
  input  logic signed [IN_W-1:0]  mul_result_18_i,
  input  logic signed [IN_W-1:0]  mul_result_19_i,
  input  logic signed [IN_W-1:0]  mul_result_20_i,
  input  logic signed [IN_W-1:0]  mul_result_21_i,
  input  logic signed [IN_W-1:0]  mul_result_22_i,
  input  logic signed [IN_W-1:0]  mul_result_23_i,
  input  logic signed [IN_W-1:0]  mul_result_24_i,
  input  logic                    in_valid,
  input  logic                    ch_first_i,
  input  logic                    ch_last_i,
  input  logic signed [ACC_W-1:0] bias_i,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] conv_result_o,
  output logic                    conv_result_valid
);

  // Sideband depth matches the five tree stages so flags meet the S5 sum.
  localparam int SB_D = ADD_TREE_LATENCY - 2;

  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  logic signed [IN_W-1:0]  prod [N_PRODUCTS];
  logic signed [ACC_W-1:0] s0   [N_PRODUCTS];
  logic signed [ACC_W-1:0] s1   [13];
  logic signed [ACC_W-1:0] s2   [7];
  logic signed [ACC_W-1:0] s3   [4];
  logic signed [ACC_W-1:0] s4   [2];
  logic signed [ACC_W-1:0] s5   [1];

  logic [SB_D-1:0]         v_pipe;
  logic [SB_D-1:0]         f_pipe;
  logic [SB_D-1:0]         l_pipe;

  logic signed [ACC_W-1:0] acc;
  logic                    done;

  logic signed [ACC_W:0]   biased;
  logic signed [ACC_W:0]   shifted;
  logic signed [ACC_W:0]   t_c;

  assign prod[0]  = mul_result_0_i;
  assign prod[1]  = mul_result_1_i;
  assign prod[2]  = mul_result_2_i;
  assign prod[3]  = mul_result_3_i;
  assign prod[4]  = mul_result_4_i;
  assign prod[5]  = mul_result_5_i;
  assign prod[6]  = mul_result_6_i;
  assign prod[7]  = mul_result_7_i;
  assign prod[8]  = mul_result_8_i;
  assign prod[9]  = mul_result_9_i;
  assign prod[10] = mul_result_10_i;
  assign prod[11] = mul_result_11_i;
  assign prod[12] = mul_result_12_i;
  assign prod[13] = mul_result_13_i;
  assign prod[14] = mul_result_14_i;
  assign prod[15] = mul_result_15_i;
  assign prod[16] = mul_result_16_i;
  assign prod[17] = mul_result_17_i;
  assign prod[18] = mul_result_18_i;
  assign prod[19] = mul_result_19_i;
  assign prod[20] = mul_result_20_i;
  assign prod[21] = mul_result_21_i;
  assign prod[22] = mul_result_22_i;
  assign prod[23] = mul_result_23_i;
  assign prod[24] = mul_result_24_i;

  // Sign-extend every product to accumulator width before the first add.
  always_comb begin
    for (int k = 0; k < N_PRODUCTS; k++) begin
      s0[k] = {{(ACC_W-IN_W){prod[k][IN_W-1]}}, prod[k]};
    end
  end

  add_pair_stage #(.N_IN(25), .W(ACC_W)) u_s1 (.clk(clk), .rst(rst), .in_data(s0), .out_data(s1));
  add_pair_stage #(.N_IN(13), .W(ACC_W)) u_s2 (.clk(clk), .rst(rst), .in_data(s1), .out_data(s2));
  add_pair_stage #(.N_IN(7),  .W(ACC_W)) u_s3 (.clk(clk), .rst(rst), .in_data(s2), .out_data(s3));
  add_pair_stage #(.N_IN(4),  .W(ACC_W)) u_s4 (.clk(clk), .rst(rst), .in_data(s3), .out_data(s4));
  add_pair_stage #(.N_IN(2),  .W(ACC_W)) u_s5 (.clk(clk), .rst(rst), .in_data(s4), .out_data(s5));

  // Carry valid/first/last alongside the tree so they align with the S5 sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      f_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[SB_D-2:0], in_valid};
      f_pipe <= {f_pipe[SB_D-2:0], ch_first_i & in_valid};
      l_pipe <= {l_pipe[SB_D-2:0], ch_last_i & in_valid};
    end
  end

  // S6: restart on ch_first, otherwise add onto the running channel sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      done <= 1'b0;
    end else begin
      done <= v_pipe[SB_D-1] & l_pipe[SB_D-1];
      if (v_pipe[SB_D-1]) begin
        acc <= f_pipe[SB_D-1] ? s5[0] : acc + s5[0];
      end
    end
  end

  // Bias in one extra bit so the add cannot wrap, then floor-shift, ReLU, clamp.
  always_comb begin
    biased  = {acc[ACC_W-1], acc} + {bias_i[ACC_W-1], bias_i};
    shifted = biased >>> FRAC_SHIFT;
    t_c     = shifted;
    if (relu_en && shifted < 0) begin
      t_c = '0;
    end else if (shifted > OUT_MAX) begin
      t_c = OUT_MAX;
    end else if (shifted < OUT_MIN) begin
      t_c = OUT_MIN;
    end
  end

  // S7: capture the completed pixel and strobe for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_result_o     <= '0;
      conv_result_valid <= 1'b0;
    end else begin
      conv_result_valid <= done;
      if (done) begin
        conv_result_o <= t_c[OUT_W-1:0];
      end
    end
  end

endmodule
